pipe_stage_reg: RTL and testbench

//  Generic parametrised inter-stage pipeline register (IF/ID .. MEM/WB) with valid/ready handshake.

---
 rtl/pipe_stage_reg_pkg.sv | 24 ++
 rtl/pipe_stage_reg_if.sv | 26 ++
 rtl/pipe_stage_reg_slot.sv | 32 +++
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the inter-stage pipeline register.
// State encoding plus per-boundary field widths used to pack bundles.
package pipe_stage_reg_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int IF_ID_DATA_W  = 64;
    localparam int IF_ID_CTRL_W  = 1;
    localparam int ID_EX_DATA_W  = 128;
    localparam int ID_EX_CTRL_W  = 12;
    localparam int EX_MEM_DATA_W = 96;
    localparam int EX_MEM_CTRL_W = 6;
    localparam int MEM_WB_DATA_W = 69;
    localparam int MEM_WB_CTRL_W = 3;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bundle between two pipeline stages.
// The stage register is the slave; whoever feeds and drains it is the master.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One held word (data + ctrl) with load and ctrl-only clear.
// Updates on the falling clock edge, async active-low reset.
module pipe_stage_reg_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic [DATA_W+CTRL_W-1:0] r_word;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_word <= '0;
        end else if (i_load) begin
            r_word <= {i_data, i_ctrl};
        end else if (i_clr) begin
            r_word[CTRL_W-1:0] <= '0;
        end
    end

    assign o_data = r_word[DATA_W+CTRL_W-1:CTRL_W];
    assign o_ctrl = r_word[CTRL_W-1:0];

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic stage-boundary register with stall, flush and optional skid slot.
// Main slot always drives the outputs; the skid slot queues behind it.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus
);

    state_t            r_state;
    state_t            w_next;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_drain;
    logic              w_main_ld;
    logic              w_main_clr;
    logic              w_skid_ld;
    logic              w_from_skid;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_drain  = bus.out_valid & bus.out_ready;

    always_comb begin
        w_next      = r_state;
        w_main_ld   = 1'b0;
        w_main_clr  = 1'b0;
        w_skid_ld   = 1'b0;
        w_from_skid = 1'b0;
        if (flush) begin
            w_next     = EMPTY;
            w_main_clr = 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_next    = ONE;
                        w_main_ld = 1'b1;
                    end
                end
                ONE: begin
                    // Without a skid slot an accept always overwrites main
                    if (w_accept && (w_drain || SKID == 0)) begin
                        w_main_ld = 1'b1;
                    end else if (w_accept) begin
                        w_next    = FULL;
                        w_skid_ld = 1'b1;
                    end else if (w_drain) begin
                        w_next     = EMPTY;
                        w_main_clr = 1'b1;
                    end
                end
                FULL: begin
                    if (w_drain) begin
                        w_next      = ONE;
                        w_main_ld   = 1'b1;
                        w_from_skid = 1'b1;
                    end
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    generate
        if (SKID != 0) begin : g_reg_rdy
            logic r_in_ready;
            always_ff @(negedge clk or negedge reset) begin
                if (!reset) begin
                    r_in_ready <= 1'b0;
                end else begin
                    r_in_ready <= (w_next != FULL);
                end
            end
            assign w_in_ready = r_in_ready;
        end else begin : g_comb_rdy
            assign w_in_ready = reset & (~bus.out_valid | bus.out_ready);
        end
    endgenerate

    generate
        if (SKID != 0) begin : g_skid
            pipe_stage_reg_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk    (clk),
                .reset  (reset),
                .i_load (w_skid_ld),
                .i_clr  (flush),
                .i_data (bus.in_data),
                .i_ctrl (bus.in_ctrl),
                .o_data (w_skid_data),
                .o_ctrl (w_skid_ctrl)
            );
        end else begin : g_no_skid
            assign w_skid_data = '0;
            assign w_skid_ctrl = '0;
        end
    endgenerate

    assign w_main_data = w_from_skid ? w_skid_data : bus.in_data;
    assign w_main_ctrl = w_from_skid ? w_skid_ctrl : bus.in_ctrl;

    pipe_stage_reg_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_main_ld),
        .i_clr  (w_main_clr),
        .i_data (w_main_data),
        .i_ctrl (w_main_ctrl),
        .o_data (bus.out_data),
        .o_ctrl (bus.out_ctrl)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state != EMPTY);
    assign bus.occupancy = {r_state == FULL, r_state == ONE};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: drivers queue expected words, monitors pop on drain.
// Instance A has the skid slot; instance B is single-entry with wide ctrl.
module tb_pipe_stage_reg;

    logic clk;
    logic reset;
    logic flush_a;
    logic flush_b;
    int   n_chk;
    int   n_err;

    logic [35:0] qa[$];
    logic [38:0] qb[$];
    logic [35:0] exp_a;
    logic [38:0] exp_b;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(4)) ba ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(7)) bb ();

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(1)) u_a (
        .clk   (clk),
        .reset (reset),
        .flush (flush_a),
        .bus   (ba)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(7), .SKID(0)) u_b (
        .clk   (clk),
        .reset (reset),
        .flush (flush_b),
        .bus   (bb)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            if (ba.out_valid && ba.out_ready) begin
                n_chk++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL mon_a unexpected got=%0h required=none",
                             {ba.out_data, ba.out_ctrl});
                end else begin
                    exp_a = qa.pop_front();
                    if ({ba.out_data, ba.out_ctrl} !== exp_a) begin
                        n_err++;
                        $display("FAIL mon_a word got=%0h required=%0h",
                                 {ba.out_data, ba.out_ctrl}, exp_a);
                    end
                end
            end else if (!ba.out_valid) begin
                n_chk++;
                if (ba.out_ctrl !== 4'h0) begin
                    n_err++;
                    $display("FAIL mon_a idle_ctrl got=%0h required=0",
                             ba.out_ctrl);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            if (bb.out_valid && bb.out_ready) begin
                n_chk++;
                if (qb.size() == 0) begin
                    n_err++;
                    $display("FAIL mon_b unexpected got=%0h required=none",
                             {bb.out_data, bb.out_ctrl});
                end else begin
                    exp_b = qb.pop_front();
                    if ({bb.out_data, bb.out_ctrl} !== exp_b) begin
                        n_err++;
                        $display("FAIL mon_b word got=%0h required=%0h",
                                 {bb.out_data, bb.out_ctrl}, exp_b);
                    end
                end
            end else if (!bb.out_valid) begin
                n_chk++;
                if (bb.out_ctrl !== 7'h0) begin
                    n_err++;
                    $display("FAIL mon_b idle_ctrl got=%0h required=0",
                             bb.out_ctrl);
                end
            end
        end
    end

    task automatic push_a(input logic [31:0] d, input logic [3:0] c,
                          input bit fl);
        int n;
        n = 0;
        ba.in_valid = 1'b1;
        ba.in_data  = d;
        ba.in_ctrl  = c;
        flush_a     = fl;
        @(posedge clk);
        while (!ba.in_ready && n < 40) begin
            n++;
            @(posedge clk);
        end
        if (!ba.in_ready) begin
            n_chk++;
            n_err++;
            $display("FAIL push_a_timeout ready=0 required=1 data=%0h", d);
        end else if (!fl) begin
            qa.push_back({d, c});
        end
        @(negedge clk);
        #2;
        ba.in_valid = 1'b0;
        flush_a     = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] d, input logic [6:0] c);
        int n;
        n = 0;
        bb.in_valid = 1'b1;
        bb.in_data  = d;
        bb.in_ctrl  = c;
        @(posedge clk);
        while (!bb.in_ready && n < 40) begin
            n++;
            @(posedge clk);
        end
        if (!bb.in_ready) begin
            n_chk++;
            n_err++;
            $display("FAIL push_b_timeout ready=0 required=1 data=%0h", d);
        end else begin
            qb.push_back({d, c});
        end
        @(negedge clk);
        #2;
        bb.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        ba.in_valid = 1'b0;
        ba.in_data = '0;
        ba.in_ctrl = '0;
        ba.out_ready = 1'b0;
        bb.in_valid = 1'b0;
        bb.in_data = '0;
        bb.in_ctrl = '0;
        bb.out_ready = 1'b0;

        #1;
        chk("rst_valid", 64'(ba.out_valid), 64'h0);
        chk("rst_occ", 64'(ba.occupancy), 64'h0);
        chk("rst_ready", 64'(ba.in_ready), 64'h0);
        chk("rst_data", 64'(ba.out_data), 64'h0);
        chk("rst_ready_b", 64'(bb.in_ready), 64'h0);
        #11;
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("rel_ready", 64'(ba.in_ready), 64'h1);

        // streaming with downstream always ready
        ba.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_a(32'h11 + i, i[3:0], 1'b0);
            chk("str_occ", 64'(ba.occupancy), 64'h1);
            chk("str_ready", 64'(ba.in_ready), 64'h1);
            if (i == 0) begin
                chk("str_lat_valid", 64'(ba.out_valid), 64'h1);
                chk("str_lat_data", 64'(ba.out_data), 64'h11);
            end
        end
        idle(2);
        chk("str_empty", 64'(ba.occupancy), 64'h0);

        // backpressure into the skid slot
        ba.out_ready = 1'b0;
        push_a(32'hA, 4'h3, 1'b0);
        chk("bp_occ1", 64'(ba.occupancy), 64'h1);
        push_a(32'hB, 4'h6, 1'b0);
        chk("bp_occ2", 64'(ba.occupancy), 64'h2);
        chk("bp_ready", 64'(ba.in_ready), 64'h0);
        ba.in_valid = 1'b1;
        ba.in_data = 32'hC;
        ba.in_ctrl = 4'h9;
        idle(3);
        chk("bp_hold_occ", 64'(ba.occupancy), 64'h2);
        chk("bp_hold_data", 64'(ba.out_data), 64'hA);
        chk("bp_hold_ctrl", 64'(ba.out_ctrl), 64'h3);
        ba.out_ready = 1'b1;
        push_a(32'hC, 4'h9, 1'b0);
        idle(3);
        chk("bp_drained", 64'(ba.occupancy), 64'h0);

        // flush while full, with a word offered upstream
        ba.out_ready = 1'b0;
        push_a(32'h21, 4'h1, 1'b0);
        push_a(32'h22, 4'h2, 1'b0);
        chk("fl_full", 64'(ba.occupancy), 64'h2);
        flush_a = 1'b1;
        ba.in_valid = 1'b1;
        ba.in_data = 32'hD;
        ba.in_ctrl = 4'hF;
        @(negedge clk);
        #2;
        flush_a = 1'b0;
        ba.in_valid = 1'b0;
        qa.delete();
        chk("fl_valid", 64'(ba.out_valid), 64'h0);
        chk("fl_ctrl", 64'(ba.out_ctrl), 64'h0);
        chk("fl_occ", 64'(ba.occupancy), 64'h0);
        chk("fl_ready", 64'(ba.in_ready), 64'h1);
        // a word accepted during flush is consumed but dropped
        push_a(32'h33, 4'h7, 1'b1);
        chk("fl_acc_occ", 64'(ba.occupancy), 64'h0);
        chk("fl_acc_valid", 64'(ba.out_valid), 64'h0);
        ba.out_ready = 1'b1;
        push_a(32'h34, 4'h4, 1'b0);
        idle(3);

        // async reset while full
        ba.out_ready = 1'b0;
        push_a(32'h41, 4'h1, 1'b0);
        push_a(32'h42, 4'h2, 1'b0);
        chk("ar_full", 64'(ba.occupancy), 64'h2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        qa.delete();
        #1;
        chk("ar_valid", 64'(ba.out_valid), 64'h0);
        chk("ar_ctrl", 64'(ba.out_ctrl), 64'h0);
        chk("ar_occ", 64'(ba.occupancy), 64'h0);
        chk("ar_ready", 64'(ba.in_ready), 64'h0);
        idle(1);
        chk("ar_ready_low", 64'(ba.in_ready), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_rel_pre", 64'(ba.in_ready), 64'h0);
        idle(1);
        chk("ar_rel_post", 64'(ba.in_ready), 64'h1);

        // single-entry instance, wide ctrl
        bb.out_ready = 1'b0;
        push_b(32'h1, 7'h55);
        chk("b_valid", 64'(bb.out_valid), 64'h1);
        chk("b_ctrl", 64'(bb.out_ctrl), 64'h55);
        chk("b_ready_stall", 64'(bb.in_ready), 64'h0);
        bb.out_ready = 1'b1;
        #1;
        chk("b_ready_go", 64'(bb.in_ready), 64'h1);
        push_b(32'h5, 7'h2A);
        chk("b_pass_valid", 64'(bb.out_valid), 64'h1);
        chk("b_pass_data", 64'(bb.out_data), 64'h5);
        chk("b_pass_occ", 64'(bb.occupancy), 64'h1);
        idle(1);
        chk("b_empty_valid", 64'(bb.out_valid), 64'h0);
        chk("b_empty_ctrl", 64'(bb.out_ctrl), 64'h0);
        chk("b_empty_occ", 64'(bb.occupancy), 64'h0);

        idle(3);
        chk("qa_left", 64'(qa.size()), 64'h0);
        chk("qb_left", 64'(qb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
